// File: rtl/studio2_vdma_fetch.sv
// Display-DMA responder for the RCA Studio II pixie path: fetches display RAM bytes
// on DMAO requests and emulates the interrupt routine's R0 row/repeat pointer handling.
module studio2_vdma_fetch #(
  parameter logic [15:0] VRAM_BASE      = 16'h0900,
  parameter int          BYTES_PER_LINE = 8,
  parameter int          LINE_REPEAT    = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        int_i,
  input  logic        dmao_i,
  output logic        mem_rd,
  output logic [15:0] mem_a,
  input  logic [7:0]  mem_q,
  output logic [7:0]  dma_data,
  output logic        dma_valid,
  output logic        line_done,
  output logic        short_line,
  output logic [4:0]  row_index
);

  localparam int         BPL_LOG2 = $clog2(BYTES_PER_LINE);
  localparam logic [5:0] BPL_LAST = 6'(BYTES_PER_LINE - 1);
  localparam logic [7:0] BPL_STEP = 8'(BYTES_PER_LINE);
  localparam logic [2:0] REP_LAST = 3'(LINE_REPEAT - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_line_start;
  logic [5:0] r_byte_cnt;
  logic [2:0] r_rep_cnt;
  logic       r_dmao_d;
  logic       r_int_d;
  logic [7:0] r_dma_data;
  logic       r_dma_valid;
  logic       r_line_done;
  logic       r_short_line;

  logic       w_dmao_rise;
  logic       w_int_rise;
  logic       w_last_byte;
  logic [7:0] w_offset;

  assign w_dmao_rise = dmao_i & ~r_dmao_d;
  assign w_int_rise  = int_i & ~r_int_d;
  assign w_last_byte = (r_byte_cnt == BPL_LAST);
  // Offset is 8 bits wide so the address wraps inside the 256-byte display page.
  assign w_offset    = r_line_start + {2'b00, r_byte_cnt};

  // NOTE: every register below uses non-blocking assignment so all state updates
  // see the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state      <= ST_IDLE;
      r_line_start <= 8'h00;
      r_byte_cnt   <= 6'd0;
      r_rep_cnt    <= 3'd0;
      r_dmao_d     <= 1'b0;
      r_int_d      <= 1'b0;
      r_dma_data   <= 8'h00;
      r_dma_valid  <= 1'b0;
      r_line_done  <= 1'b0;
      r_short_line <= 1'b0;
    end else begin
      r_dmao_d     <= dmao_i;
      r_int_d      <= int_i;
      r_dma_valid  <= 1'b0;
      r_line_done  <= 1'b0;
      r_short_line <= 1'b0;
      // Frame start wins over everything, including an in-flight capture.
      if (w_int_rise) begin
        r_state      <= ST_IDLE;
        r_line_start <= 8'h00;
        r_byte_cnt   <= 6'd0;
        r_rep_cnt    <= 3'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_dmao_rise) r_state <= ST_FETCH;
          end
          ST_FETCH: begin
            r_state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            r_dma_data  <= mem_q;
            r_dma_valid <= 1'b1;
            if (w_last_byte || !dmao_i) begin
              r_line_done  <= 1'b1;
              r_short_line <= !w_last_byte;
              r_byte_cnt   <= 6'd0;
              r_state      <= w_last_byte ? ST_HOLD : ST_IDLE;
              if (r_rep_cnt == REP_LAST) begin
                r_rep_cnt    <= 3'd0;
                r_line_start <= r_line_start + BPL_STEP;
              end else begin
                r_rep_cnt <= r_rep_cnt + 3'd1;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 6'd1;
              r_state    <= ST_FETCH;
            end
          end
          default: begin
            if (!dmao_i) r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_rd     = (r_state == ST_FETCH);
  assign mem_a      = mem_rd ? {VRAM_BASE[15:8], w_offset} : 16'h0000;
  assign dma_data   = r_dma_data;
  assign dma_valid  = r_dma_valid;
  assign line_done  = r_line_done;
  assign short_line = r_short_line;
  assign row_index  = 5'(r_line_start >> BPL_LOG2);

endmodule

// File: tb/tb_studio2_vdma_fetch.sv
// Directed bench for studio2_vdma_fetch: a byte-wide RAM model answers reads one clk
// later, and a negedge monitor logs reads, delivered bytes and burst-end pulses.
module tb_studio2_vdma_fetch;

  logic        clk = 1'b0;
  logic        resetq;
  logic        int_i;
  logic        dmao_i;
  logic        mem_rd;
  logic [15:0] mem_a;
  logic [7:0]  mem_q;
  logic [7:0]  dma_data;
  logic        dma_valid;
  logic        line_done;
  logic        short_line;
  logic [4:0]  row_index;

  studio2_vdma_fetch dut (
    .clk        (clk),
    .resetq     (resetq),
    .int_i      (int_i),
    .dmao_i     (dmao_i),
    .mem_rd     (mem_rd),
    .mem_a      (mem_a),
    .mem_q      (mem_q),
    .dma_data   (dma_data),
    .dma_valid  (dma_valid),
    .line_done  (line_done),
    .short_line (short_line),
    .row_index  (row_index)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [256];
  logic [15:0] rd_q [$];
  int          rd_cyc [$];
  logic [7:0]  dv_q [$];
  int          dv_cyc [$];
  int          ld_cnt;
  int          ld_cyc;
  int          sl_cnt;
  int          cyc = 0;
  int          start_cyc;
  int          n_tests = 0;
  int          n_fail = 0;

  // Data is valid only in the clk after the strobe; any other clk returns junk.
  always @(posedge clk) begin
    mem_q <= mem_rd ? ram[mem_a[7:0]] : 8'hEE;
    cyc   <= cyc + 1;
  end

  always @(negedge clk) begin
    if (resetq) begin
      if (mem_rd) begin
        rd_q.push_back(mem_a);
        rd_cyc.push_back(cyc);
      end
      if (dma_valid) begin
        dv_q.push_back(dma_data);
        dv_cyc.push_back(cyc);
      end
      if (line_done) begin
        ld_cnt++;
        ld_cyc = cyc;
      end
      if (short_line) sl_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    rd_q.delete();
    rd_cyc.delete();
    dv_q.delete();
    dv_cyc.delete();
    ld_cnt = 0;
    ld_cyc = -1;
    sl_cnt = 0;
  endtask

  task automatic do_reset();
    resetq = 1'b0;
    dmao_i = 1'b0;
    int_i  = 1'b0;
    tick(2);
    resetq = 1'b1;
    tick(1);
  endtask

  task automatic full_burst();
    clear_log();
    dmao_i    = 1'b1;
    start_cyc = cyc;
    tick(20);
    dmao_i = 1'b0;
    tick(3);
  endtask

  task automatic wait_dv(input int n, input string tag);
    int k = 0;
    while (dv_q.size() < n && k < 60) begin
      tick(1);
      k++;
    end
    check(tag, 32'(dv_q.size() >= n), 32'd1);
  endtask

  task automatic check_burst(input string tag, input logic [15:0] base);
    check({tag, "_nrd"}, 32'(rd_q.size()), 32'd8);
    check({tag, "_ld"}, 32'(ld_cnt), 32'd1);
    check({tag, "_sl"}, 32'(sl_cnt), 32'd0);
    if (rd_q.size() == 8) begin
      check({tag, "_a0"}, 32'(rd_q[0]), 32'(base));
      check({tag, "_a7"}, 32'(rd_q[7]), 32'(base + 16'd7));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i + 8'h10);
    resetq = 1'b0;
    dmao_i = 1'b0;
    int_i  = 1'b0;
    tick(2);

    // Reset state
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_a", 32'(mem_a), 32'd0);
    check("rst_dma_data", 32'(dma_data), 32'd0);
    check("rst_dma_valid", 32'(dma_valid), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_short", 32'(short_line), 32'd0);
    check("rst_row", 32'(row_index), 32'd0);
    resetq = 1'b1;
    tick(1);

    // First burst: 8 reads, timing and data
    full_burst();
    check_burst("b1", 16'h0900);
    check("b1_dv_n", 32'(dv_q.size()), 32'd8);
    if (rd_q.size() == 8 && dv_q.size() == 8) begin
      check("b1_first_rd_lat", 32'(rd_cyc[0] - start_cyc), 32'd1);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("b1_a%0d", i), 32'(rd_q[i]), 32'(16'h0900 + 16'(i)));
        check($sformatf("b1_d%0d", i), 32'(dv_q[i]), 32'(8'h10 + 8'(i)));
        check($sformatf("b1_lat%0d", i), 32'(dv_cyc[i] - rd_cyc[i]), 32'd2);
      end
      check("b1_ld_with_last", 32'(ld_cyc), 32'(dv_cyc[7]));
    end
    check("b1_hold_data", 32'(dma_data), 32'h17);

    // Line repeat: bursts 2-4 replay row 0, burst 5 moves to row 1
    for (int b = 2; b <= 4; b++) begin
      full_burst();
      check_burst($sformatf("rep%0d", b), 16'h0900);
    end
    check("rep_row1", 32'(row_index), 32'd1);
    full_burst();
    check_burst("rep5", 16'h0908);
    if (dv_q.size() > 0) check("rep5_d0", 32'(dv_q[0]), 32'h18);

    // Short line: request dropped right after the 3rd byte; the byte already
    // being fetched is still delivered, then short_line ends the burst.
    do_reset();
    clear_log();
    dmao_i = 1'b1;
    wait_dv(3, "short_wait");
    dmao_i = 1'b0;
    tick(5);
    check("short_sl", 32'(sl_cnt), 32'd1);
    check("short_ld", 32'(ld_cnt), 32'd1);
    check("short_dv_n", 32'(dv_q.size()), 32'd4);
    full_burst();
    check_burst("short_next", 16'h0900);
    full_burst();
    check("short_row0", 32'(row_index), 32'd0);
    full_burst();
    check("short_row1", 32'(row_index), 32'd1);

    // Page wrap after 32 rows x 4 repeats
    do_reset();
    for (int b = 1; b <= 128; b++) begin
      full_burst();
      if (b == 124) check("wrap_row31", 32'(row_index), 32'd31);
    end
    check_burst("wrap_b128", 16'h09F8);
    if (dv_q.size() == 8) check("wrap_d_last", 32'(dv_q[7]), 32'h0F);
    check("wrap_row0", 32'(row_index), 32'd0);
    full_burst();
    check_burst("wrap_b129", 16'h0900);

    // Frame interrupt during CAPTURE of byte 5, second repeat of row 3
    do_reset();
    for (int b = 1; b <= 13; b++) full_burst();
    check("int_row3", 32'(row_index), 32'd3);
    clear_log();
    dmao_i = 1'b1;
    wait_dv(4, "int_wait");
    tick(1);
    int_i = 1'b1;
    tick(5);
    check("int_dv_n", 32'(dv_q.size()), 32'd4);
    check("int_rd_n", 32'(rd_q.size()), 32'd5);
    check("int_ld", 32'(ld_cnt), 32'd0);
    check("int_row0", 32'(row_index), 32'd0);
    int_i  = 1'b0;
    dmao_i = 1'b0;
    tick(2);
    full_burst();
    check_burst("int_next", 16'h0900);
    full_burst();
    full_burst();
    check("int_rep_row0", 32'(row_index), 32'd0);
    full_burst();
    check("int_rep_row1", 32'(row_index), 32'd1);

    // Asynchronous reset while byte 3 is being fetched
    do_reset();
    clear_log();
    dmao_i = 1'b1;
    begin
      int k = 0;
      while (!(rd_q.size() >= 3 && mem_rd) && k < 40) begin
        tick(1);
        k++;
      end
    end
    check("arst_mid_fetch", 32'(mem_rd), 32'd1);
    check("arst_pre_valid", 32'(dma_valid), 32'd1);
    #2;
    resetq = 1'b0;
    dmao_i = 1'b0;
    #1;
    check("arst_mem_rd", 32'(mem_rd), 32'd0);
    check("arst_dma_valid", 32'(dma_valid), 32'd0);
    check("arst_line_done", 32'(line_done), 32'd0);
    check("arst_dma_data", 32'(dma_data), 32'd0);
    tick(2);
    resetq = 1'b1;
    clear_log();
    tick(6);
    check("arst_no_rd", 32'(rd_q.size()), 32'd0);
    full_burst();
    check_burst("arst_next", 16'h0900);
    if (rd_cyc.size() > 0) check("arst_lat", 32'(rd_cyc[0] - start_cyc), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
